// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the sequential ALU: opcode encodings,
//               FSM state encoding and bit positions inside the flag vector.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcode encodings
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_NAND = 3'b001;
    localparam logic [2:0] ALU_LT   = 3'b010;
    localparam logic [2:0] ALU_SHL  = 3'b011;
    localparam logic [2:0] ALU_SRA  = 3'b100;
    localparam logic [2:0] ALU_EQ   = 3'b101;
    localparam logic [2:0] ALU_MUL  = 3'b110;
    localparam logic [2:0] ALU_SUB  = 3'b111;

    // Control FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    // Bit positions in the registered flag vector
    localparam int c_flag_zero  = 0;
    localparam int c_flag_carry = 1;
    localparam int c_flag_neg   = 2;
    localparam int c_flag_ovf   = 3;
    localparam int c_num_flags  = 4;

endpackage
`default_nettype wire

// File: rtl/alu_seq_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_iter
// Description : Iterative datapath for SHL, SRA and MUL. One step per cycle
//               while the step counter is non-zero. The next-step value is
//               exposed combinationally so the owner can register the final
//               result on the edge that performs the last step.
// Ports       : clk, rst_n        - clock, async active-low reset
//               start             - load operands and step count
//               op                - ALU_SHL / ALU_SRA / ALU_MUL
//               opa, opb          - operand A (shifted value / multiplicand),
//                                   operand B (multiplier)
//               count             - number of steps to run (>=1)
//               last              - current cycle performs the final step
//               step_result       - low WIDTH bits after this cycle's step
//               step_carry        - shift-out bit or multiply high-half flag
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    input  logic [SHW:0]       count,
    output logic               last,
    output logic [WIDTH-1:0]   step_result,
    output logic               step_carry
);

    localparam logic [SHW:0] c_cnt_one = {{SHW{1'b0}}, 1'b1};

    // r_acc: for MUL the {high, low} partial product with the multiplier in
    // the low half; for shifts only the low half carries the operand.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [2:0]         r_op;
    logic [SHW:0]       r_cnt;

    logic [2*WIDTH-1:0] w_next_acc;
    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_sum;
    logic               w_carry;

    always_comb begin
        w_next_acc = r_acc;
        w_addend   = '0;
        w_sum      = '0;
        w_carry    = 1'b0;
        case (r_op)
            ALU_MUL: begin
                // Shift-add: add multiplicand to the high half when the
                // current multiplier bit is set, then shift the pair right.
                w_addend   = r_acc[0] ? {1'b0, r_mcand} : '0;
                w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;
                w_next_acc = {w_sum, r_acc[WIDTH-1:1]};
                w_carry    = |w_next_acc[2*WIDTH-1:WIDTH];
            end
            ALU_SHL: begin
                w_next_acc = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], 1'b0};
                w_carry    = r_acc[WIDTH-1];
            end
            ALU_SRA: begin
                w_next_acc = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
                w_carry    = r_acc[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_op    <= ALU_ADD;
            r_cnt   <= '0;
        end else if (start) begin
            r_op    <= op;
            r_mcand <= opa;
            r_acc   <= (op == ALU_MUL) ? {{WIDTH{1'b0}}, opb} : {{WIDTH{1'b0}}, opa};
            r_cnt   <= count;
        end else if (r_cnt != '0) begin
            r_acc   <= w_next_acc;
            r_cnt   <= r_cnt - c_cnt_one;
        end
    end

    assign last        = (r_cnt == c_cnt_one);
    assign step_result = w_next_acc[WIDTH-1:0];
    assign step_carry  = w_carry;

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Clocked ALU with valid/ready handshakes on both sides.
//               Single-cycle ops are computed here; shifts by k>=1 and
//               multiplies run in alu_seq_iter.
// Ports       : clk, rst_n          - clock, async active-low reset
//               in_valid/in_ready   - request handshake
//               op, data1, data2    - opcode and operands
//                                     (data2[SHW-1:0] = shift amount)
//               out_valid/out_ready - result handshake
//               result              - registered result
//               zero, carry, negative, overflow - registered flags
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   data1,
    input  logic [WIDTH-1:0]   data2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               carry,
    output logic               negative,
    output logic               overflow
);

    localparam logic [SHW:0] c_mul_steps = (SHW+1)'(WIDTH);

    alu_state_t r_state, w_next_state;

    logic [WIDTH-1:0]       r_result;
    logic [c_num_flags-1:0] r_flags;

    logic                   w_accept;
    logic                   w_drain;
    logic [SHW-1:0]         w_k;
    logic                   w_multi;
    logic [SHW:0]           w_iter_cnt;

    logic [WIDTH:0]         w_add;
    logic [WIDTH:0]         w_sub;
    logic [WIDTH-1:0]       w_sc_result;
    logic                   w_sc_carry;
    logic                   w_sc_ovf;
    logic                   w_sc_zero;

    logic                   w_iter_last;
    logic [WIDTH-1:0]       w_iter_result;
    logic                   w_iter_carry;

    // Handshakes
    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_drain   = (r_state == ST_DONE) && out_ready;

    // Shifts by zero complete in one cycle like the other simple ops
    assign w_k        = data2[SHW-1:0];
    assign w_multi    = (op == ALU_MUL) || (((op == ALU_SHL) || (op == ALU_SRA)) && (w_k != '0));
    assign w_iter_cnt = (op == ALU_MUL) ? c_mul_steps : {1'b0, w_k};

    // Single-cycle datapath
    assign w_add = {1'b0, data1} + {1'b0, data2};
    assign w_sub = {1'b0, data1} - {1'b0, data2};   // w_sub[WIDTH] is the borrow

    always_comb begin
        w_sc_result = '0;
        w_sc_carry  = 1'b0;
        w_sc_ovf    = 1'b0;
        case (op)
            ALU_ADD: begin
                w_sc_result = w_add[WIDTH-1:0];
                w_sc_carry  = w_add[WIDTH];
                w_sc_ovf    = (data1[WIDTH-1] == data2[WIDTH-1]) &&
                              (w_add[WIDTH-1] != data1[WIDTH-1]);
            end
            ALU_SUB: begin
                w_sc_result = w_sub[WIDTH-1:0];
                w_sc_carry  = ~w_sub[WIDTH];
                w_sc_ovf    = (data1[WIDTH-1] != data2[WIDTH-1]) &&
                              (w_sub[WIDTH-1] != data1[WIDTH-1]);
            end
            ALU_NAND: w_sc_result = ~(data1 & data2);
            ALU_LT:   w_sc_result = {{(WIDTH-1){1'b0}}, (data1 < data2)};
            ALU_SHL,
            ALU_SRA:  w_sc_result = data1;      // only reached with k == 0
            default:  w_sc_result = '0;         // EQ; MUL never takes this path
        endcase
    end

    assign w_sc_zero = (op == ALU_EQ) ? (data1 == data2) : (w_sc_result == '0);

    alu_seq_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (w_accept && w_multi),
        .op          (op),
        .opa         (data1),
        .opb         (data2),
        .count       (w_iter_cnt),
        .last        (w_iter_last),
        .step_result (w_iter_result),
        .step_carry  (w_iter_carry)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_multi ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (w_iter_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_accept) begin
                    w_next_state = w_multi ? ST_BUSY : ST_DONE;
                end else if (w_drain) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Result/flag registers: loaded at a single-cycle accept or on the
    // final iterative step; otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_accept && !w_multi) begin
            r_result              <= w_sc_result;
            r_flags[c_flag_zero]  <= w_sc_zero;
            r_flags[c_flag_carry] <= w_sc_carry;
            r_flags[c_flag_neg]   <= w_sc_result[WIDTH-1];
            r_flags[c_flag_ovf]   <= w_sc_ovf;
        end else if ((r_state == ST_BUSY) && w_iter_last) begin
            r_result              <= w_iter_result;
            r_flags[c_flag_zero]  <= (w_iter_result == '0);
            r_flags[c_flag_carry] <= w_iter_carry;
            r_flags[c_flag_neg]   <= w_iter_result[WIDTH-1];
            r_flags[c_flag_ovf]   <= 1'b0;
        end
    end

    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign zero      = r_flags[c_flag_zero];
    assign carry     = r_flags[c_flag_carry];
    assign negative  = r_flags[c_flag_neg];
    assign overflow  = r_flags[c_flag_ovf];

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Scoreboard bench for alu_seq (WIDTH=8). Stimulus pushes the
//               reference model's expected response; a monitor compares
//               outputs, latency and handshake behaviour as they appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int W   = 8;
    localparam int SHW = 3;

    typedef struct {
        logic [W-1:0] res;
        logic         z, c, n, v;
        int           acc;
        int           lat;
        logic [2:0]   op;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] data1, data2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero, carry, negative, overflow;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   rand_ready = 1'b0;
    bit   seen = 1'b0;
    exp_t sb[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .data1     (data1),
        .data2     (data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .negative  (negative),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp_v);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference model computed from the arithmetic definition of each op
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int ua, ub, sa, sb_, k, r, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb_ = int'($signed(b));
        k  = int'(b[SHW-1:0]);
        r  = 0;
        e.c = 1'b0;
        e.v = 1'b0;
        e.lat = 1;
        e.op = o;
        e.acc = 0;
        case (o)
            3'd0: begin
                r = ua + ub; e.c = (r > 255);
                sr = sa + sb_; e.v = (sr > 127) || (sr < -128);
            end
            3'd7: begin
                r = ua - ub; e.c = (ua >= ub);
                sr = sa - sb_; e.v = (sr > 127) || (sr < -128);
            end
            3'd1: r = ~(ua & ub);
            3'd2: r = (ua < ub) ? 1 : 0;
            3'd3: begin
                r = ua << k;
                e.c = (k > 0) ? (((ua >> (W - k)) & 1) != 0) : 1'b0;
                e.lat = k + 1;
            end
            3'd4: begin
                r = sa >>> k;
                e.c = (k > 0) ? (((ua >> (k - 1)) & 1) != 0) : 1'b0;
                e.lat = k + 1;
            end
            3'd5: r = 0;
            default: begin
                r = ua * ub;
                e.c = ((r >> W) != 0);
                e.lat = W + 1;
            end
        endcase
        e.res = r[W-1:0];
        e.z = (o == 3'd5) ? (a == b) : (e.res == '0);
        e.n = e.res[W-1];
        return e;
    endfunction

    // Monitor: compares the scoreboard head against whatever the DUT shows
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_out_valid", 1, 0);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk(cyc == sb[0].acc + sb[0].lat, $sformatf("latency_op%0d", sb[0].op),
                            cyc - sb[0].acc, sb[0].lat);
                    end
                    chk({result, zero, carry, negative, overflow} ===
                        {sb[0].res, sb[0].z, sb[0].c, sb[0].n, sb[0].v},
                        $sformatf("result_flags_op%0d", sb[0].op),
                        int'({result, zero, carry, negative, overflow}),
                        int'({sb[0].res, sb[0].z, sb[0].c, sb[0].n, sb[0].v}));
                    if (!out_ready) begin
                        chk(in_ready === 1'b0, "in_ready_while_held", int'(in_ready), 0);
                    end else begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end else if (sb.size() > 0 && cyc > sb[0].acc) begin
                chk(in_ready === 1'b0, "in_ready_while_busy", int'(in_ready), 0);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        bit   got;
        exp_t e;
        got = 1'b0;
        in_valid = 1'b1;
        op = o;
        data1 = a;
        data2 = b;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        if (got) begin
            e = model(o, a, b);
            e.acc = cyc - 1;
            sb.push_back(e);
        end else begin
            chk(1'b0, "accept_timeout", 0, 1);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 300 && sb.size() != 0; t++) @(posedge clk);
        #1;
        chk(sb.size() == 0, "drain_timeout", sb.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        chk(out_valid === 1'b0, {tag, "_out_valid"}, int'(out_valid), 0);
        chk(in_ready === 1'b1, {tag, "_in_ready"}, int'(in_ready), 1);
        chk({result, zero, carry, negative, overflow} === '0, {tag, "_result_flags"},
            int'({result, zero, carry, negative, overflow}), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        op = 3'd0;
        data1 = '0;
        data2 = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        issue(3'd0, 8'h7F, 8'h01);          // ADD overflow
        issue(3'd4, 8'h90, 8'h03);          // SRA by 3
        issue(3'd3, 8'h81, 8'h01);          // SHL by 1
        issue(3'd6, 8'h12, 8'h10);          // MUL with high half
        issue(3'd6, 8'h05, 8'h03);
        drain();

        // Backpressure, then drain and accept in the same cycle
        out_ready = 1'b0;
        issue(3'd7, 8'h03, 8'h05);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(3'd5, 8'h55, 8'h55);
        issue(3'd2, 8'h03, 8'h03);
        issue(3'd2, 8'h02, 8'h03);
        issue(3'd1, 8'hFF, 8'hFF);
        issue(3'd3, 8'hA5, 8'h08);          // shift amount 0
        issue(3'd0, 8'hFF, 8'h01);          // ADD carry out
        drain();

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 250; i++) begin
            issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        end
        rand_ready = 1'b0;
        drain();

        // Reset in cycle 4 of a multiply
        issue(3'd6, 8'hC3, 8'h7E);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_op_reset");
        sb.delete();
        seen = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(3'd0, 8'h01, 8'h01);
        drain();
        repeat (12) @(posedge clk);
        #1;
        chk(out_valid === 1'b0, "no_stale_output", int'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
